// File: rtl/led_sched_pkg.sv
// Shared types and defaults for the LED frame scheduler.
// Default timing constants assume a 40 MHz system clock.
package led_sched_pkg;

  localparam int COLOR_W            = 24;
  localparam int LATCH_CYCLES_DEF   = 2000;
  localparam int REFRESH_CYCLES_DEF = 400000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LATCH = 3'd4
  } sched_state_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_cycle_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
// Used for the latch gap and, when auto refresh is built in, the refresh interval.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over counting, and counting saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// Walks every face/pixel of the WS2812 chain, hands each colour to the serializer,
// then holds the latch gap. Optional periodic re-send is built with AUTO_REFRESH_EN.
module led_frame_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_FACES       = 6,
  parameter int PIXELS_PER_FACE = 64,
  parameter int LATCH_CYCLES    = LATCH_CYCLES_DEF,
`ifdef AUTO_REFRESH_EN
  parameter int REFRESH_CYCLES  = REFRESH_CYCLES_DEF,
`endif
  parameter int FACE_W          = width_of(NUM_FACES),
  parameter int PIX_W           = width_of(PIXELS_PER_FACE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_req,
  output logic [FACE_W-1:0]  face_idx,
  output logic [PIX_W-1:0]   pixel_idx,
  output logic               pix_valid,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               ser_start,
  output logic [COLOR_W-1:0] ser_data,
  input  logic               ser_done,
  output logic               latch,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         frame_count
);

  localparam int                 LATCH_W    = width_of(LATCH_CYCLES);
  localparam logic [LATCH_W-1:0] LATCH_LOAD = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [FACE_W-1:0]  FACE_LAST  = FACE_W'(NUM_FACES - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIXELS_PER_FACE - 1);

  sched_state_t       state_q, state_d;
  logic [FACE_W-1:0]  face_q, face_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [COLOR_W-1:0] ser_data_q, ser_data_d;
  logic               ser_start_q, ser_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic               pending_q, pending_d;
  logic               latch_load_s;
  logic               latch_zero_s;
  logic               start_s;
  logic               last_pix_s;

  cycle_timer #(.WIDTH(LATCH_W)) u_latch_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (latch_load_s),
    .load_val (LATCH_LOAD),
    .en       (state_q == ST_LATCH),
    .zero     (latch_zero_s)
  );

`ifdef AUTO_REFRESH_EN
  localparam int                   REFRESH_W    = width_of(REFRESH_CYCLES);
  localparam logic [REFRESH_W-1:0] REFRESH_LOAD = REFRESH_W'(REFRESH_CYCLES - 1);

  logic refresh_zero_s;
  logic refresh_due_s;
  logic refresh_armed_q, refresh_armed_d;

  // Reloaded at every frame completion and frozen outside IDLE.
  cycle_timer #(.WIDTH(REFRESH_W)) u_refresh_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (frame_done_d),
    .load_val (REFRESH_LOAD),
    .en       (state_q == ST_IDLE),
    .zero     (refresh_zero_s)
  );

  // Armed by the first completed frame so a fresh reset does not fire a re-send at once.
  assign refresh_armed_d = refresh_armed_q | frame_done_d;
  assign refresh_due_s   = refresh_armed_q & refresh_zero_s & (state_q == ST_IDLE);
  assign start_s         = frame_req | refresh_due_s;

  // Refresh arm flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_armed_q <= 1'b0;
    end else begin
      refresh_armed_q <= refresh_armed_d;
    end
  end
`else
  assign start_s = frame_req;
`endif

  assign last_pix_s = (face_q == FACE_LAST) && (pix_q == PIX_LAST);

  // Next-state and registered-output decode for the frame walk.
  always_comb begin
    state_d       = state_q;
    face_d        = face_q;
    pix_d         = pix_q;
    ser_data_d    = ser_data_q;
    ser_start_d   = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    latch_load_s  = 1'b0;
    if (frame_req && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_FETCH;
          face_d  = '0;
          pix_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ser_data_d  = pix_color;
        ser_start_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!ser_done) begin
          state_d = ST_WAIT;
        end else if (last_pix_s) begin
          state_d      = ST_LATCH;
          latch_load_s = 1'b1;
        end else if (pix_q == PIX_LAST) begin
          state_d = ST_FETCH;
          pix_d   = '0;
          face_d  = face_q + FACE_W'(1);
        end else begin
          state_d = ST_FETCH;
          pix_d   = pix_q + PIX_W'(1);
        end
      end
      ST_LATCH: begin
        if (latch_zero_s) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          pending_d     = 1'b0;
          // A request landing on the exit cycle restarts just like a stored one.
          if (pending_q || frame_req) begin
            state_d = ST_FETCH;
            face_d  = '0;
            pix_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_LATCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      face_q        <= '0;
      pix_q         <= '0;
      ser_data_q    <= '0;
      ser_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      face_q        <= face_d;
      pix_q         <= pix_d;
      ser_data_q    <= ser_data_d;
      ser_start_q   <= ser_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      pending_q     <= pending_d;
    end
  end

  assign face_idx    = face_q;
  assign pixel_idx   = pix_q;
  assign pix_valid   = (state_q == ST_FETCH);
  assign latch       = (state_q == ST_LATCH);
  assign ser_start   = ser_start_q;
  assign ser_data    = ser_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: 2 faces x 4 pixels, 8-cycle latch,
// serializer answering 5 cycles after each start.
module tb_led_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_req;
  logic [0:0]  face_idx;
  logic [1:0]  pixel_idx;
  logic        pix_valid;
  logic [23:0] pix_color;
  logic        ser_start;
  logic [23:0] ser_data;
  logic        ser_done;
  logic        ser_done_m = 1'b0;
  logic        ser_done_x = 1'b0;
  logic        latch;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          latch_cnt = 0;
  int          done_cnt = 0;
  int          last_latch_cyc = 0;
  int          done_cyc = 0;
  logic [23:0] starts[$];

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_color(input int f, input int p);
    return {8'hC0 + 8'(f), 8'h30 + 8'(p), 8'(f * 16 + p) ^ 8'h5A};
  endfunction

  assign pix_color = pix_valid ? exp_color(int'(face_idx), int'(pixel_idx)) : 24'h000000;
  assign ser_done  = ser_done_m | ser_done_x;

  led_frame_scheduler #(
    .NUM_FACES       (2),
    .PIXELS_PER_FACE (4),
    .LATCH_CYCLES    (8)
`ifdef AUTO_REFRESH_EN
    , .REFRESH_CYCLES (20)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_req   (frame_req),
    .face_idx    (face_idx),
    .pixel_idx   (pixel_idx),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .ser_start   (ser_start),
    .ser_data    (ser_data),
    .ser_done    (ser_done),
    .latch       (latch),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  // Serializer model: done pulse 5 cycles after the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (ser_start === 1'b1) begin
        repeat (5) @(negedge clk);
        ser_done_m = 1'b1;
        @(negedge clk);
        ser_done_m = 1'b0;
      end
    end
  end

  // Observation log.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ser_start === 1'b1) starts.push_back(ser_data);
    if (latch === 1'b1) begin
      latch_cnt      <= latch_cnt + 1;
      last_latch_cyc <= cyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int  s0;
    int  b0;
    int  d0;
    int  k;
    bit  found;

    reset     = 1'b0;
    frame_req = 1'b0;
    tick();
    tick();
    chk("rst_face", 32'(face_idx), 32'd0);
    chk("rst_pixel", 32'(pixel_idx), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_ser_start", 32'(ser_start), 32'd0);
    chk("rst_ser_data", 32'(ser_data), 32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b1;
    tick();

    // Single frame.
    s0 = starts.size(); b0 = latch_cnt; d0 = done_cnt;
    pulse_req();
    chk("f1_fetch_valid", 32'(pix_valid), 32'd1);
    chk("f1_fetch_busy", 32'(busy), 32'd1);
    chk("f1_fetch_idx", {30'd0, face_idx, pixel_idx}, 32'd0);
    chk("f1_fetch_nostart", 32'(ser_start), 32'd0);
    tick();
    chk("f1_send_start", 32'(ser_start), 32'd1);
    chk("f1_send_data", 32'(ser_data), 32'(exp_color(0, 0)));
    chk("f1_send_valid", 32'(pix_valid), 32'd0);
    wait_done("f1_done_seen");
    chk("f1_nstarts", 32'(starts.size() - s0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (s0 + i < starts.size())
        chk($sformatf("f1_data%0d", i), 32'(starts[s0 + i]), 32'(exp_color(i / 4, i % 4)));
    end
    chk("f1_latch_len", 32'(latch_cnt - b0), 32'd8);
    chk("f1_ndone", 32'(done_cnt - d0), 32'd1);
    chk("f1_done_after_latch", 32'(done_cyc - last_latch_cyc), 32'd1);
    chk("f1_count", 32'(frame_count), 32'd1);
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_latch_off", 32'(latch), 32'd0);

    // Three requests during pixel (0,2) collapse into one immediate re-send.
    s0 = starts.size(); b0 = latch_cnt; d0 = done_cnt;
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pix_valid === 1'b1 && face_idx === 1'b0 && pixel_idx === 2'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("p_reach_02", 32'(found), 32'd1);
    frame_req = 1'b1;
    tick(); tick(); tick();
    frame_req = 1'b0;
    wait_done("p_done1_seen");
    chk("p_count1", 32'(frame_count), 32'd2);
    chk("p_busy_restart", 32'(busy), 32'd1);
    chk("p_fetch_restart", 32'(pix_valid), 32'd1);
    chk("p_restart_idx", {30'd0, face_idx, pixel_idx}, 32'd0);
    wait_done("p_done2_seen");
    chk("p_count2", 32'(frame_count), 32'd3);
    chk("p_idle", 32'(busy), 32'd0);
    chk("p_nstarts", 32'(starts.size() - s0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (s0 + i < starts.size())
        chk($sformatf("p_data%0d", i), 32'(starts[s0 + i]), 32'(exp_color((i % 8) / 4, i % 4)));
    end
    chk("p_latch_len", 32'(latch_cnt - b0), 32'd16);
    chk("p_ndone", 32'(done_cnt - d0), 32'd2);

    // Request on the final latch cycle.
    b0 = latch_cnt;
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (latch === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("lx_latch_seen", 32'(found), 32'd1);
    repeat (7) tick();
    chk("lx_last_latch", 32'(latch), 32'd1);
    pulse_req();
    chk("lx_done", 32'(frame_done), 32'd1);
    chk("lx_count", 32'(frame_count), 32'd4);
    chk("lx_restart_fetch", 32'(pix_valid), 32'd1);
    chk("lx_busy", 32'(busy), 32'd1);
    wait_done("lx_done2_seen");
    chk("lx_count2", 32'(frame_count), 32'd5);
    chk("lx_idle", 32'(busy), 32'd0);
    chk("lx_latch_len", 32'(latch_cnt - b0), 32'd16);

    // Spurious serializer done while idle.
    ser_done_x = 1'b1;
    tick();
    ser_done_x = 1'b0;
    chk("sp_busy", 32'(busy), 32'd0);
    chk("sp_valid", 32'(pix_valid), 32'd0);
    chk("sp_start", 32'(ser_start), 32'd0);
    tick();
    chk("sp_busy2", 32'(busy), 32'd0);
    chk("sp_count", 32'(frame_count), 32'd5);

    // Reset while waiting on pixel (1,1).
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ser_start === 1'b1 && face_idx === 1'b1 && pixel_idx === 2'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("r_reach_11", 32'(found), 32'd1);
    tick();
    chk("r_in_wait", {29'd0, busy, pix_valid, ser_start}, 32'd4);
    b0 = latch_cnt;
    reset = 1'b0;
    tick();
    chk("r_face", 32'(face_idx), 32'd0);
    chk("r_pixel", 32'(pixel_idx), 32'd0);
    chk("r_valid", 32'(pix_valid), 32'd0);
    chk("r_start", 32'(ser_start), 32'd0);
    chk("r_data", 32'(ser_data), 32'd0);
    chk("r_latch", 32'(latch), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_done", 32'(frame_done), 32'd0);
    chk("r_count", 32'(frame_count), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("r_no_latch", 32'(latch_cnt - b0), 32'd0);
    chk("r_idle", 32'(busy), 32'd0);
    pulse_req();
    chk("r2_valid", 32'(pix_valid), 32'd1);
    chk("r2_idx", {30'd0, face_idx, pixel_idx}, 32'd0);
    tick();
    chk("r2_data", 32'(ser_data), 32'(exp_color(0, 0)));
    wait_done("r2_done_seen");
    chk("r2_count", 32'(frame_count), 32'd1);

`ifdef AUTO_REFRESH_EN
    // Auto re-send 20 idle cycles after frame_done.
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pix_valid === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("ar_interval", 32'(k), 32'd20);
    wait_done("ar_done_seen");
    chk("ar_count", 32'(frame_count), 32'd2);
    repeat (19) tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk("ar_coincide_fetch", 32'(pix_valid), 32'd1);
    wait_done("ar_done2_seen");
    chk("ar_count2", 32'(frame_count), 32'd3);
    chk("ar_single_frame", 32'(busy), 32'd0);
`else
    k = 0;
    repeat (25) tick();
    chk("nr_stay_idle", {31'd0, busy}, 32'(k));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Sequences one full refresh of the chained WS2812 panel string. The scheduler walks every face and pixel in order, fetches each 24-bit colour from the pixel colour source, and hands it to the bit serializer through a start/done handshake. After the last pixel it enforces the latch (line-low) gap. It sits between the SPI load-complete pulse and the serializer, and decides when frames are (re)sent.

## Interface
- NUM_FACES, 6, panels chained on one data line
- PIXELS_PER_FACE, 64, LEDs per panel
- LATCH_CYCLES, 2000, line-low gap after a frame (50 µs at 40 MHz)
- REFRESH_CYCLES, 400000, idle interval before auto re-send (10 ms at 40 MHz)
- clk  input  1  system clock, 40 MHz
- reset  input  1  asynchronous, active-low (0 = reset)
- frame_req  input  1  one-cycle pulse: new orientation loaded
- face_idx  output  max(1,$clog2(NUM_FACES))  face being fetched
- pixel_idx  output  $clog2(PIXELS_PER_FACE)  pixel within face (serializer order)
- pix_valid  output  1  colour source must drive pix_color this cycle
- pix_color  input  24  colour for {face_idx, pixel_idx}, combinational from source
- ser_start  output  1  one-cycle pulse, ser_data valid
- ser_data  output  24  registered colour word for serializer
- ser_done  input  1  one-cycle pulse: serializer finished 24 bits
- latch  output  1  high during latch gap
- busy  output  1  frame in progress (any state but IDLE)
- frame_done  output  1  one-cycle pulse, frame fully latched
- frame_count  output  8  completed frames, wraps 255→0

## Operation
- States: IDLE, FETCH, SEND, WAIT, LATCH.
- IDLE → FETCH on a start event (frame_req, or refresh_due when compiled in). face_idx and pixel_idx load 0.
- FETCH (1 cycle): pix_valid=1; ser_data ← pix_color; → SEND.
- SEND (1 cycle): ser_start=1; → WAIT.
- WAIT: hold until ser_done.
  - Not last pixel of the frame: advance pixel_idx; on wrap PIXELS_PER_FACE-1 → 0, increment face_idx. → FETCH.
  - Last pixel (face NUM_FACES-1, pixel PIXELS_PER_FACE-1): → LATCH, load latch counter.
- LATCH: latch=1 for exactly LATCH_CYCLES cycles. Then frame_count++ and frame_done pulses. If pending is set → FETCH (pending cleared), else → IDLE.
- pending: a single-deep flag, set by frame_req while busy. Multiple requests collapse into one re-send. A frame_req in the same cycle as the LATCH exit counts as pending, so the frame restarts.
- ser_done outside WAIT is ignored. ser_start never reasserts before ser_done.
- Reset: state IDLE, pending=0, counters 0. All outputs 0: face_idx, pixel_idx, pix_valid, ser_start, ser_data, latch, busy, frame_done, frame_count.
- Reset mid-frame aborts immediately with no latch gap. The next frame_req restarts from face 0, pixel 0.

## Timing
- Cycle N: frame_req in IDLE.
  - N+1: FETCH, pix_valid=1, busy=1.
  - N+2: SEND, ser_start=1, ser_data valid and held until the next FETCH.
- ser_done at cycle M leads to FETCH at M+1. Per-pixel overhead is 2 cycles plus serializer time.
- latch is high from the cycle after the final ser_done for LATCH_CYCLES cycles.
- frame_done and the frame_count increment occur in the cycle after the last latch cycle.
- All outputs are registered except pix_valid and latch, which decode from state.
- Counter widths are $clog2 of their parameter. The latch counter loads LATCH_CYCLES-1 and counts down to 0.

## Configuration
- AUTO_REFRESH_EN defined:
  - A refresh counter clears on frame_done and counts only in IDLE.
  - At REFRESH_CYCLES-1 it raises refresh_due, which starts a frame exactly like frame_req.
  - frame_req in the same cycle produces one frame, not two.
- AUTO_REFRESH_EN undefined: no refresh counter is instantiated, and frames start only on frame_req.

## Structure
- Shared package led_sched_pkg holds:
  - state enum sched_state_t
  - COLOR_W = 24
  - default LATCH_CYCLES and REFRESH_CYCLES for 40 MHz
- One sub-module, cycle_timer: a loadable down-counter with a zero flag. It is instantiated once for the latch gap and, under AUTO_REFRESH_EN, once for refresh.

## Test plan
- Bench configuration: NUM_FACES=2, PIXELS_PER_FACE=4, LATCH_CYCLES=8. The serializer model returns ser_done 5 cycles after ser_start.
- Single frame_req → 8 ser_start pulses with ser_data = pix_color for indices (0,0)…(1,3) in order; latch high exactly 8 cycles; one frame_done; frame_count=1; busy=0.
- frame_req ×3 during pixel (0,2) → exactly one extra frame follows immediately after LATCH with no IDLE cycle; frame_count=2.
- frame_req on the LATCH exit cycle → frame restarts (pending path); frame_done still pulses for the first frame.
- reset low during WAIT at pixel (1,1) → all outputs 0 next edge, no latch; subsequent frame_req starts at (0,0).
- With AUTO_REFRESH_EN and REFRESH_CYCLES=20, no frame_req after the first frame → a new frame starts 20 IDLE cycles after frame_done. Spurious ser_done in IDLE → no state change.
